// File: rtl/cv32e40x_div.sv
// rtl/cv32e40x_div.sv - serial radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   valid_i, halt_i    EX-stage request; valid_i=0 with halt_i=0 kills the operation
//   operator_i         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a_i, op_b_i     dividend, divisor (sampled only in the accept cycle)
//   result_o           quotient or remainder, nonzero only in DIV_FINISH
//   ready_o, valid_o   done / result-valid handshake towards EX
//   ready_i            downstream accepts the result
//
// Optional feature macro: CV32E40X_DIV_EARLY_OUT_EN
//   When defined, leading zeros of the dividend magnitude are skipped at
//   accept, and a zero dividend finishes immediately.
module cv32e40x_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        halt_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_DIVIDE = 2'b01,
    DIV_FINISH = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] dividend_q, divisor_q, quot_q, a_orig_q;
  logic [32:0] rem_q;
  logic [5:0]  cnt_q;
  logic        sign_a_q, sign_b_q, b_zero_q;
  logic [1:0]  op_q;

  logic        is_signed, sign_a, sign_b, kill, b_zero_in, a_zero;
  logic [31:0] a_abs, b_abs, a_load;
  logic [5:0]  cnt_load;
  logic [33:0] trial;

  // operator_i[0] set means unsigned variant
  assign is_signed = ~operator_i[0];
  assign sign_a    = is_signed & op_a_i[31];
  assign sign_b    = is_signed & op_b_i[31];
  assign a_abs     = sign_a ? -op_a_i : op_a_i;
  assign b_abs     = sign_b ? -op_b_i : op_b_i;
  assign b_zero_in = (op_b_i == 32'h0);
  assign kill      = ~valid_i & ~halt_i;

`ifdef CV32E40X_DIV_EARLY_OUT_EN
  logic [5:0] lz;
  // Leading zeros of the dividend only produce zero quotient bits and leave
  // the partial remainder at zero, so they can be skipped without changing
  // the result.
  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a_abs[i]) lz = 6'(31 - i);
    end
  end
  assign a_load   = a_abs << lz;
  assign cnt_load = 6'd32 - lz;
  assign a_zero   = (a_abs == 32'h0);
`else
  assign a_load   = a_abs;
  assign cnt_load = 6'd32;
  assign a_zero   = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract. 34 bits keep the borrow visible for any 32-bit divisor.
  assign trial = {rem_q, dividend_q[31]} - {2'b00, divisor_q};

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (valid_i) state_d = (b_zero_in || a_zero) ? DIV_FINISH : DIV_DIVIDE;
        else         ready_o = 1'b1;
      end
      DIV_DIVIDE: begin
        if (cnt_q == 6'd1) state_d = DIV_FINISH;
      end
      DIV_FINISH: begin
        valid_o = 1'b1;
        if (ready_i) begin
          ready_o = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    // Kill wins over every transition and suppresses the result
    if (kill) begin
      state_d = DIV_IDLE;
      ready_o = 1'b1;
      valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      dividend_q <= 32'h0;
      divisor_q  <= 32'h0;
      quot_q     <= 32'h0;
      a_orig_q   <= 32'h0;
      rem_q      <= 33'h0;
      cnt_q      <= 6'h0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      op_q       <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && valid_i) begin
        dividend_q <= a_load;
        divisor_q  <= b_abs;
        quot_q     <= 32'h0;
        rem_q      <= 33'h0;
        cnt_q      <= cnt_load;
        a_orig_q   <= op_a_i;
        sign_a_q   <= sign_a;
        sign_b_q   <= sign_b;
        b_zero_q   <= b_zero_in;
        op_q       <= operator_i;
      end else if (state_q == DIV_DIVIDE && !kill) begin
        dividend_q <= dividend_q << 1;
        cnt_q      <= cnt_q - 6'd1;
        if (!trial[33]) begin
          rem_q  <= trial[32:0];
          quot_q <= {quot_q[30:0], 1'b1};
        end else begin
          rem_q  <= {rem_q[31:0], dividend_q[31]};
          quot_q <= {quot_q[30:0], 1'b0};
        end
      end
    end
  end

  // Signed overflow (INT_MIN / -1) needs no special case: the magnitude
  // quotient 0x80000000 is already the wrapped answer, and the remainder is 0.
  always_comb begin
    result_o = 32'h0;
    if (state_q == DIV_FINISH) begin
      if (b_zero_q) begin
        result_o = op_q[1] ? a_orig_q : 32'hFFFF_FFFF;
      end else begin
        case (op_q)
          2'b00:   result_o = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
          2'b01:   result_o = quot_q;
          2'b10:   result_o = sign_a_q ? -rem_q[31:0] : rem_q[31:0];
          default: result_o = rem_q[31:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_div.sv
// tb/tb_cv32e40x_div.sv - scoreboard testbench for cv32e40x_div
module tb_cv32e40x_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, halt_i, ready_i;
  logic [1:0]  operator_i;
  logic [31:0] op_a_i, op_b_i;
  logic [31:0] result_o;
  logic        ready_o, valid_o;

  cv32e40x_div dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .halt_i     (halt_i),
    .operator_i (operator_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

`ifdef CV32E40X_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycles from the accept cycle to the first valid_o
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int lz;
    if (b == 32'h0) return 1;
    if (!EARLY) return 33;
    m = (!op[0] && a[31]) ? -a : a;
    if (m == 32'h0) return 1;
    lz = 0;
    while (!m[31]) begin
      m = m << 1;
      lz++;
    end
    return 33 - lz;
  endfunction

  // Monitor: compares against the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'h0, valid_o}, 32'h0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - sb[0].t0), 32'(sb[0].lat));
          seen = 1'b1;
        end
        if (ready_i) begin
          check("result", result_o, sb[0].res);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int bp, input int halt_at);
    exp_t e;
    logic [31:0] r0;
    int n;
    @(posedge clk); #1;
    ready_i    = (bp == 0);
    valid_i    = 1'b1;
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    e.res = exp_res;
    e.lat = exp_lat(op, a, b);
    e.t0  = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    // Operands must be ignored once accepted
    operator_i = ~op;
    op_a_i     = $urandom;
    op_b_i     = $urandom;
    if (halt_at > 0) begin
      repeat (halt_at) @(posedge clk);
      #1;
      valid_i = 1'b0;
      halt_i  = 1'b1;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (valid_o) break;
      n++;
    end
    if (n == 100) begin
      check("timeout_valid", 32'h0, 32'h1);
      void'(sb.pop_front());
      seen = 1'b0;
    end else begin
      if (bp > 0) begin
        r0 = result_o;
        repeat (bp) begin
          @(negedge clk);
          check("bp_valid", {31'h0, valid_o}, 32'h1);
          check("bp_stable", result_o, r0);
          check("bp_ready", {31'h0, ready_o}, 32'h0);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        @(negedge clk);
      end
      check("done_ready", {31'h0, ready_o}, 32'h1);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    halt_i  = 1'b0;
    @(negedge clk);
    check("idle_valid", {31'h0, valid_o}, 32'h0);
    check("idle_result", result_o, 32'h0);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    valid_i    = 1'b1;
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; halt_i = 1'b0; ready_i = 1'b1;
    operator_i = 2'b00; op_a_i = 32'h0; op_b_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, valid_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    check("reset_ready", {31'h0, ready_o}, 32'h1);
    rst = 1'b0;

    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, 0);
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 0, 0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0, 0);
    run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 0);
    run_op(OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 0, 0);
    run_op(OP_DIVU, 32'd0, 32'd5, 32'd0, 0, 0);
    run_op(OP_DIVU, 32'd1, 32'd1, 32'd1, 0, 0);

    // Kill at iteration 10
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    valid_i = 1'b0;
    halt_i  = 1'b0;
    @(negedge clk);
    check("kill_ready", {31'h0, ready_o}, 32'h1);
    check("kill_valid", {31'h0, valid_o}, 32'h0);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 0, 0);

    // valid_i dropped while halted: no kill, result still delivered
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 5);
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0, 0);

    // Backpressure in DIV_FINISH
    run_op(OP_DIVU, 32'd12345, 32'd100, 32'd123, 5, 0);

    // Reset at iteration 20
    start_op(OP_DIVU, 32'd5000, 32'd7);
    repeat (20) @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_i = 1'b0;
    #1;
    check("midrst_valid", {31'h0, valid_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_ready", {31'h0, ready_o}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(OP_REMU, 32'd5000, 32'd7, 32'd2, 0, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
